seq_det_ctrl: RTL and testbench

Programmable serial sequence-detector controller. It accepts a bit pattern of 1..MAX_LEN bits over a config handshake, arms on command, and consumes a valid/ready serial bit stream. It detects overlapping occurrences of the pattern and counts them, stopping at a match limit or on an inactivity timeout. It sits between a register/CPU-side config port and a serial input stream, and generalises the team's fixed-pattern Mealy detectors into one reusable, sequenced resource.

---
 rtl/seq_det_pkg.sv | 17 +
 rtl/seq_det_if.sv | 40 ++++
 rtl/seq_matcher.sv | 52 +++++
 rtl/seq_det_ctrl.sv | 141 ++++++++++++++
 tb/tb_seq_det_ctrl.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/seq_det_pkg.sv
// Shared types for the programmable sequence detector.
// State encoding and error codes used by the controller and its users.
package seq_det_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOADED = 3'd1,
        ST_ARMED  = 3'd2,
        ST_DONE   = 3'd3,
        ST_ERROR  = 3'd4
    } state_e;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_CFG  = 2'b01;
    localparam logic [1:0] ERR_TMO  = 2'b10;

endpackage

// File: rtl/seq_det_if.sv
// Config, command, serial-stream and status bundle of seq_det_ctrl.
// master drives config/commands/bits; slave is the detector.
interface seq_det_if #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8,
    parameter int TMO_W   = 16,
    localparam int LEN_W  = $clog2(MAX_LEN + 1)
) ();

    logic               cfg_valid;
    logic               cfg_ready;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic [CNT_W-1:0]   cfg_limit;
    logic [TMO_W-1:0]   cfg_timeout;
    logic               start;
    logic               abort;
    logic               clr;
    logic               bit_valid;
    logic               bit_in;
    logic               bit_ready;
    logic               match;
    logic [CNT_W-1:0]   match_count;
    logic               busy;
    logic               done;
    logic [1:0]         err;

    modport master (
        output cfg_valid, cfg_pattern, cfg_len, cfg_limit, cfg_timeout,
        output start, abort, clr, bit_valid, bit_in,
        input  cfg_ready, bit_ready, match, match_count, busy, done, err
    );

    modport slave (
        input  cfg_valid, cfg_pattern, cfg_len, cfg_limit, cfg_timeout,
        input  start, abort, clr, bit_valid, bit_in,
        output cfg_ready, bit_ready, match, match_count, busy, done, err
    );

endinterface

// File: rtl/seq_matcher.sv
// History shift register, fill counter and pattern compare.
// hit is combinational on the bit being shifted in this cycle.
module seq_matcher #(
    parameter int MAX_LEN = 8,
    localparam int LEN_W  = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               shift_en,
    input  logic               bit_in,
    input  logic               flush,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LEN_W-1:0]   len,
    output logic               hit
);

    logic [MAX_LEN-1:0] hist_q, hist_d, hist_nx;
    logic [MAX_LEN-1:0] rev, aligned, mask;
    logic [LEN_W-1:0]   fill_q, fill_d, fill_nx, sh;

    // Newest bit sits in hist[0]; pattern[len-1-i] is realigned onto hist[i]
    always_comb begin
        hist_nx = {hist_q[MAX_LEN-2:0], bit_in};
        fill_nx = (fill_q == LEN_W'(MAX_LEN)) ? fill_q : fill_q + LEN_W'(1);
        rev     = {<<{pattern}};
        sh      = LEN_W'(MAX_LEN) - len;
        aligned = rev >> sh;
        mask    = {MAX_LEN{1'b1}} >> sh;
        hit     = shift_en && !flush && (fill_nx >= len) &&
                  (((hist_nx ^ aligned) & mask) == '0);
        hist_d  = hist_q;
        fill_d  = fill_q;
        if (flush) begin
            hist_d = '0;
            fill_d = '0;
        end else if (shift_en) begin
            hist_d = hist_nx;
            fill_d = fill_nx;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hist_q <= '0;
            fill_q <= '0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
        end
    end

endmodule

// File: rtl/seq_det_ctrl.sv
// Programmable serial sequence-detector controller.
// Sequences config, arming, match counting, limit and inactivity timeout.
module seq_det_ctrl
    import seq_det_pkg::*;
#(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8,
    parameter int TMO_W   = 16,
    localparam int LEN_W  = $clog2(MAX_LEN + 1)
) (
    input logic       clk,
    input logic       reset,
    seq_det_if.slave  bus
);

    state_e             state_q, state_d;
    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [CNT_W-1:0]   lim_q, lim_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [TMO_W-1:0]   tcnt_q, tcnt_d, tcnt_inc;
    logic               match_q, match_d;
    logic [1:0]         err_q, err_d;
    logic               armed, hs, shift_en, flush, hit, cfg_ok;

    assign armed    = (state_q == ST_ARMED);
    assign hs       = bus.bit_valid & armed;
    assign shift_en = hs & ~bus.abort;
    assign flush    = (state_q == ST_LOADED) & bus.start & ~bus.abort;
    assign cfg_ok   = (bus.cfg_len != '0) &&
                      (bus.cfg_len <= LEN_W'(MAX_LEN));
    assign cnt_inc  = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
    assign tcnt_inc = tcnt_q + TMO_W'(1);

    assign bus.cfg_ready   = (state_q == ST_IDLE);
    assign bus.bit_ready   = armed;
    assign bus.busy        = armed;
    assign bus.done        = (state_q == ST_DONE);
    assign bus.match       = match_q;
    assign bus.match_count = cnt_q;
    assign bus.err         = err_q;

    seq_matcher #(.MAX_LEN(MAX_LEN)) u_matcher (
        .clk      (clk),
        .reset    (reset),
        .shift_en (shift_en),
        .bit_in   (bus.bit_in),
        .flush    (flush),
        .pattern  (pat_q),
        .len      (len_q),
        .hit      (hit)
    );

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        len_d   = len_q;
        lim_d   = lim_q;
        tmo_d   = tmo_q;
        cnt_d   = cnt_q;
        tcnt_d  = tcnt_q;
        err_d   = err_q;
        match_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.cfg_valid && cfg_ok) begin
                    pat_d   = bus.cfg_pattern;
                    len_d   = bus.cfg_len;
                    lim_d   = bus.cfg_limit;
                    tmo_d   = bus.cfg_timeout;
                    state_d = ST_LOADED;
                end else if (bus.cfg_valid) begin
                    err_d   = ERR_CFG;
                    state_d = ST_ERROR;
                end
            end
            ST_LOADED: begin
                if (bus.abort) begin
                    state_d = ST_IDLE;
                end else if (bus.start) begin
                    cnt_d   = '0;
                    tcnt_d  = '0;
                    state_d = ST_ARMED;
                end
            end
            ST_ARMED: begin
                // abort wins over a coincident bit, which is then dropped
                if (bus.abort) begin
                    state_d = ST_IDLE;
                end else if (hs) begin
                    tcnt_d = '0;
                    if (hit) begin
                        match_d = 1'b1;
                        cnt_d   = cnt_inc;
                        if (lim_q != '0 && cnt_inc == lim_q)
                            state_d = ST_DONE;
                    end
                end else begin
                    tcnt_d = tcnt_inc;
                    if (tmo_q != '0 && tcnt_inc == tmo_q) begin
                        err_d   = ERR_TMO;
                        state_d = ST_ERROR;
                    end
                end
            end
            ST_DONE, ST_ERROR: begin
                if (bus.clr) begin
                    err_d   = ERR_NONE;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            pat_q   <= '0;
            len_q   <= '0;
            lim_q   <= '0;
            tmo_q   <= '0;
            cnt_q   <= '0;
            tcnt_q  <= '0;
            match_q <= 1'b0;
            err_q   <= ERR_NONE;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            lim_q   <= lim_d;
            tmo_q   <= tmo_d;
            cnt_q   <= cnt_d;
            tcnt_q  <= tcnt_d;
            match_q <= match_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Bench for seq_det_ctrl: directed scenarios with literal expectations
// plus a randomized run against a queue-based behavioural model.
module tb_seq_det_ctrl;

    logic clk = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;

    seq_det_if #(.MAX_LEN(8), .CNT_W(8), .TMO_W(16)) bus ();

    seq_det_ctrl #(.MAX_LEN(8), .CNT_W(8), .TMO_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Model: 0 idle, 1 loaded, 2 armed, 3 done, 4 error
    int         m_mode = 0;
    logic [7:0] m_pat  = '0;
    int         m_len  = 0;
    int         m_lim  = 0;
    int         m_tmo  = 0;
    int         m_cnt  = 0;
    int         m_idle = 0;
    int         m_err  = 0;
    bit         m_match = 0;
    bit         m_hist[$];

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
        end
    endtask

    function automatic bit model_hit();
        int n;
        n = m_hist.size();
        if (n < m_len) return 1'b0;
        for (int k = 0; k < m_len; k++)
            if (m_hist[n - m_len + k] != bit'(m_pat >> k)) return 1'b0;
        return 1'b1;
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge reset);
            m_match = 0;
            if (!reset) begin
                m_mode = 0; m_cnt = 0; m_idle = 0; m_err = 0;
                m_hist.delete();
            end else begin
                case (m_mode)
                    0: if (bus.cfg_valid) begin
                        if (bus.cfg_len >= 1 && bus.cfg_len <= 8) begin
                            m_pat = bus.cfg_pattern;
                            m_len = int'(bus.cfg_len);
                            m_lim = int'(bus.cfg_limit);
                            m_tmo = int'(bus.cfg_timeout);
                            m_mode = 1;
                        end else begin
                            m_err = 1; m_mode = 4;
                        end
                    end
                    1: if (bus.abort) m_mode = 0;
                       else if (bus.start) begin
                           m_mode = 2; m_cnt = 0; m_idle = 0;
                           m_hist.delete();
                       end
                    2: if (bus.abort) m_mode = 0;
                       else if (bus.bit_valid) begin
                           m_idle = 0;
                           m_hist.push_back(bus.bit_in);
                           if (m_hist.size() > 8) void'(m_hist.pop_front());
                           if (model_hit()) begin
                               m_match = 1;
                               m_cnt = (m_cnt == 255) ? 255 : m_cnt + 1;
                               if (m_lim != 0 && m_cnt == m_lim) m_mode = 3;
                           end
                       end else begin
                           m_idle++;
                           if (m_tmo != 0 && m_idle == m_tmo) begin
                               m_err = 2; m_mode = 4;
                           end
                       end
                    default: if (bus.clr) begin
                        m_mode = 0; m_err = 0;
                    end
                endcase
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("cfg_ready", bus.cfg_ready, m_mode == 0);
            chk("bit_ready", bus.bit_ready, m_mode == 2);
            chk("busy", bus.busy, m_mode == 2);
            chk("done", bus.done, m_mode == 3);
            chk("match", bus.match, m_match);
            chk("match_count", bus.match_count, m_cnt);
            chk("err", bus.err, m_err);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        bus.cfg_valid = 0; bus.cfg_pattern = '0; bus.cfg_len = '0;
        bus.cfg_limit = '0; bus.cfg_timeout = '0;
        bus.start = 0; bus.abort = 0; bus.clr = 0;
        bus.bit_valid = 0; bus.bit_in = 0;
    endtask

    task automatic do_cfg(input logic [7:0] p, input logic [3:0] l,
                          input logic [7:0] lim, input logic [15:0] t);
        bus.cfg_valid = 1; bus.cfg_pattern = p; bus.cfg_len = l;
        bus.cfg_limit = lim; bus.cfg_timeout = t;
        cyc();
        bus.cfg_valid = 0;
    endtask

    task automatic do_start();
        bus.start = 1; cyc(); bus.start = 0;
    endtask

    task automatic do_abort();
        bus.abort = 1; cyc(); bus.abort = 0;
    endtask

    task automatic do_clr();
        bus.clr = 1; cyc(); bus.clr = 0;
    endtask

    task automatic send(input bit b);
        bus.bit_valid = 1; bus.bit_in = b; cyc(); bus.bit_valid = 0;
    endtask

    bit basic[6] = '{1, 0, 1, 0, 1, 1};
    int pulses;

    initial begin
        reset = 0;
        idle_in();
        repeat (2) cyc();
        chk("rst_cfg_ready", bus.cfg_ready, 1);
        chk("rst_count", bus.match_count, 0);
        chk("rst_busy", bus.busy, 0);
        @(negedge clk) reset = 1;
        cyc();

        do_cfg(8'h35, 6, 0, 0);
        do_start();
        for (int i = 0; i < 6; i++) begin
            send(basic[i]);
            chk("basic_match", bus.match, (i == 5));
        end
        chk("basic_count", bus.match_count, 1);
        do_abort();
        chk("abort_idle", bus.cfg_ready, 1);

        do_cfg(8'h03, 2, 0, 0);
        do_start();
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            send(1);
            pulses += int'(bus.match);
        end
        chk("overlap_pulses", pulses, 3);
        chk("overlap_count", bus.match_count, 3);
        do_abort();

        do_cfg(8'h01, 1, 2, 0);
        do_start();
        send(1); send(0); send(1);
        chk("limit_done", bus.done, 1);
        chk("limit_bit_ready", bus.bit_ready, 0);
        chk("limit_count", bus.match_count, 2);
        send(1);
        chk("limit_no_accept", bus.match_count, 2);
        chk("limit_no_match", bus.match, 0);
        do_clr();
        chk("limit_clr", bus.cfg_ready, 1);

        do_cfg(8'h00, 1, 0, 4);
        do_start();
        repeat (3) cyc();
        chk("tmo_pre_busy", bus.busy, 1);
        chk("tmo_pre_err", bus.err, 0);
        cyc();
        chk("tmo_err", bus.err, 2);
        chk("tmo_busy", bus.busy, 0);
        do_clr();
        chk("tmo_clr", bus.cfg_ready, 1);
        chk("tmo_clr_err", bus.err, 0);

        do_cfg(8'h01, 0, 0, 0);
        chk("badlen0_err", bus.err, 1);
        do_clr();
        chk("badlen0_clr", bus.cfg_ready, 1);
        do_cfg(8'h01, 9, 0, 0);
        chk("badlen9_err", bus.err, 1);
        do_clr();

        do_cfg(8'h03, 2, 0, 0);
        do_start();
        send(1); send(1);
        chk("coll_pre_count", bus.match_count, 1);
        bus.abort = 1;
        send(1);
        bus.abort = 0;
        chk("coll_match", bus.match, 0);
        chk("coll_count", bus.match_count, 1);
        chk("coll_idle", bus.cfg_ready, 1);

        do_cfg(8'h35, 6, 0, 0);
        do_start();
        for (int i = 0; i < 5; i++) send(basic[i]);
        reset = 0;
        #2;
        chk("mid_rst_cfg_ready", bus.cfg_ready, 1);
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_count", bus.match_count, 0);
        @(negedge clk) reset = 1;
        cyc();
        do_cfg(8'h35, 6, 0, 0);
        do_start();
        send(1);
        chk("mid_rst_flushed", bus.match, 0);
        for (int i = 1; i < 6; i++) send(basic[i]);
        chk("mid_rst_rematch", bus.match, 1);
        do_abort();

        for (int c = 0; c < 4000; c++) begin
            bus.cfg_valid   = ($urandom_range(0, 7) == 0);
            bus.cfg_pattern = 8'($urandom);
            bus.cfg_len     = ($urandom_range(0, 9) == 0) ?
                              4'($urandom_range(0, 15)) :
                              4'($urandom_range(1, 3));
            bus.cfg_limit   = 8'($urandom_range(0, 6));
            bus.cfg_timeout = 16'($urandom_range(0, 6));
            bus.start       = ($urandom_range(0, 3) == 0);
            bus.abort       = ($urandom_range(0, 39) == 0);
            bus.clr         = ($urandom_range(0, 5) == 0);
            bus.bit_valid   = ($urandom_range(0, 3) != 0);
            bus.bit_in      = 1'($urandom);
            cyc();
        end
        idle_in();
        repeat (3) cyc();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
